// File: rtl/rst_seq_pkg.sv
// Shared state type, default parameters and counter sizing for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    RST,
    DLY,
    WAIT_ACK,
    DONE
  } state_e;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STAGE_DLY   = 8;
  localparam int DEF_ACK_TIMEOUT = 32;

  // Wide enough to hold the larger of the two limits without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts immediately with arst_n, releases SYNC_STAGES edges later.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  output logic sync_rst_n
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Sequenced block-reset release with optional per-stage acknowledge handshake.
// Define RST_SEQ_ACK_EN to enable the WAIT_ACK handshake and acknowledge timeout.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STAGE_DLY   = DEF_STAGE_DLY,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst_req_n,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  timeout_err
);

  localparam int CW = cnt_width(STAGE_DLY, ACK_TIMEOUT);
  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(STAGE_DLY - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_STAGES - 1);

  logic arst_n;
  logic sync_rst_n;

  assign arst_n = rst_n & rst_req_n;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk       (clk),
    .arst_n    (arst_n),
    .sync_rst_n(sync_rst_n)
  );

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic [KW-1:0]         k_q, k_d;
  logic [CW-1:0]         cnt_q, cnt_d;

`ifdef RST_SEQ_ACK_EN
  localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);
  logic [CW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic          timeout_err_q;
`else
  logic unused_ack;
  assign unused_ack = ^stage_ack;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST;
      stage_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RST_SEQ_ACK_EN
  // The error flag survives rst_req_n pulses; only power-on reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if (tmo_hit) timeout_err_q <= 1'b1;
    end
  end
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
`ifdef RST_SEQ_ACK_EN
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
`endif
    if (!sync_rst_n) begin
      state_d = RST;
      stage_d = '0;
      k_d     = '0;
      cnt_d   = '0;
`ifdef RST_SEQ_ACK_EN
      tmo_d   = '0;
`endif
    end else begin
      unique case (state_q)
        RST: begin
          state_d = DLY;
          k_d     = '0;
          cnt_d   = '0;
        end
        DLY: begin
`ifndef RST_SEQ_ACK_EN
          // Last stage went out on the previous edge; finish one cycle later.
          if (stage_q[NUM_STAGES-1]) begin
            state_d = DONE;
          end else
`endif
          if (cnt_q == DLY_LAST) begin
            stage_d[k_q] = 1'b1;
            cnt_d        = '0;
`ifdef RST_SEQ_ACK_EN
            state_d      = WAIT_ACK;
            tmo_d        = '0;
`else
            if (k_q != K_LAST) k_d = k_q + KW'(1);
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef RST_SEQ_ACK_EN
        WAIT_ACK: begin
          if (stage_ack[k_q] || (tmo_q == TMO_LAST)) begin
            tmo_hit = !stage_ack[k_q];
            cnt_d   = '0;
            if (k_q == K_LAST) begin
              state_d = DONE;
            end else begin
              state_d = DLY;
              k_d     = k_q + KW'(1);
            end
          end else begin
            tmo_d = tmo_q + CW'(1);
          end
        end
`endif
        DONE:    state_d = DONE;
        default: state_d = RST;
      endcase
    end
  end

  assign stage_rst_n = stage_q & {NUM_STAGES{sync_rst_n}};
  assign seq_busy    = sync_rst_n & ((state_q == DLY) | (state_q == WAIT_ACK));
  assign seq_done    = sync_rst_n & (state_q == DONE);

`ifdef RST_SEQ_ACK_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed latency checks plus randomized acks/resets
// compared every cycle against an edge-count schedule model.
module tb_rst_sequencer;

  localparam int NUM   = 4;
  localparam int SYNC  = 2;
  localparam int SDLY  = 8;
  localparam int ATO   = 32;
`ifdef RST_SEQ_ACK_EN
  localparam bit ACK_MODE = 1'b1;
`else
  localparam bit ACK_MODE = 1'b0;
`endif

  localparam int P_NONE  = 0;
  localparam int P_DELAY = 1;
  localparam int P_ALL   = 2;
  localparam int P_RAND  = 3;

  logic           clk;
  logic           rst_n;
  logic           rst_req_n;
  logic [NUM-1:0] stage_ack;
  logic [NUM-1:0] stage_rst_n;
  logic           seq_busy;
  logic           seq_done;
  logic           timeout_err;

  rst_sequencer #(
    .NUM_STAGES (NUM),
    .SYNC_STAGES(SYNC),
    .STAGE_DLY  (SDLY),
    .ACK_TIMEOUT(ATO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_req_n  (rst_req_n),
    .stage_ack  (stage_ack),
    .stage_rst_n(stage_rst_n),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: release schedule in absolute edge numbers
  int n, nrel, next_rel, wait_start, done_at;
  bit waiting, done, tmo_err;

  task automatic model_clear();
    n = 0; nrel = 0; next_rel = 0; wait_start = 0; done_at = 0;
    waiting = 1'b0; done = 1'b0;
  endtask

  initial begin
    model_clear();
    tmo_err = 1'b0;
  end

  always @(posedge clk or negedge rst_n or negedge rst_req_n) begin
    if (!rst_n) tmo_err = 1'b0;
    if (!(rst_n && rst_req_n)) begin
      model_clear();
    end else begin
      n++;
      if (n == SYNC + 1) begin
        next_rel = n + SDLY;
      end else if (!done) begin
        if (next_rel != 0 && n == next_rel) begin
          nrel++;
          next_rel = 0;
          if (ACK_MODE) begin
            waiting = 1'b1;
            wait_start = n;
          end else if (nrel == NUM) begin
            done_at = n + 1;
          end else begin
            next_rel = n + SDLY;
          end
        end else if (waiting) begin
          if (stage_ack[nrel-1] || (n - wait_start == ATO)) begin
            if (!stage_ack[nrel-1]) tmo_err = 1'b1;
            waiting = 1'b0;
            if (nrel == NUM) done = 1'b1;
            else next_rel = n + SDLY;
          end
        end else if (done_at != 0 && n == done_at) begin
          done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit s;
      logic [NUM-1:0] e;
      s = rst_n && rst_req_n && (n >= SYNC);
      e = '0;
      for (int i = 0; i < NUM; i++) if (s && i < nrel) e[i] = 1'b1;
      check("stage_rst_n", stage_rst_n, e);
      check("seq_busy", seq_busy, s && (n >= SYNC + 1) && !done);
      check("seq_done", seq_done, s && done);
      check("timeout_err", timeout_err, tmo_err);
    end
  end

  // ---------------- acknowledge driver
  int pol = P_NONE;
  int never_idx = NUM;
  int ack_dly[NUM];
  int hi_cnt[NUM];

  initial begin
    stage_ack = '0;
    for (int i = 0; i < NUM; i++) begin
      ack_dly[i] = 4;
      hi_cnt[i]  = 0;
    end
  end

  always @(posedge clk) begin
    #3;
    for (int i = 0; i < NUM; i++) begin
      hi_cnt[i] = stage_rst_n[i] ? hi_cnt[i] + 1 : 0;
      case (pol)
        P_NONE:  stage_ack[i] = 1'b0;
        P_DELAY: stage_ack[i] = (i != never_idx) && (hi_cnt[i] >= ack_dly[i]);
        P_ALL:   stage_ack[i] = 1'b1;
        default: stage_ack[i] = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // idx < NUM waits for stage_rst_n[idx]; idx == NUM waits for seq_done.
  task automatic edges_until(input int idx, input int limit, output int e);
    e = 0;
    while (e < limit) begin
      @(posedge clk);
      e++;
      #1;
      if (idx < NUM ? stage_rst_n[idx] : seq_done) return;
    end
    e = -1;
  endtask

  task automatic req_pulse();
    @(posedge clk);
    #3 rst_req_n = 1'b0;
    #1 rst_req_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus
  initial begin
    int e;
    int kind;
    rst_n = 1'b1;
    rst_req_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    #18;
    check("por_stage", stage_rst_n, 0);
    check("por_busy", seq_busy, 0);
    check("por_done", seq_done, 0);
    check("por_tmo", timeout_err, 0);

    // Power-on release with no acknowledges.
    @(posedge clk); #3 rst_n = 1'b1;
    edges_until(0, 200, e);
    check("por_rel0_edges", e, SYNC + 1 + SDLY);
    repeat (5) @(posedge clk);
    #1;
    check("stall_busy", seq_busy, 1);
    check("stall_stage", stage_rst_n, 1);

    // Full sequence, each ack first sampled 4 edges after its release.
    pol = P_DELAY;
    req_pulse();
    edges_until(0, 200, e);
    check("full_rel0", e, SYNC + 1 + SDLY);
    for (int i = 1; i < NUM; i++) begin
      edges_until(i, 200, e);
      check("full_gap", e, ACK_MODE ? 4 + SDLY : SDLY);
    end
    edges_until(NUM, 200, e);
    check("full_done_edges", e, ACK_MODE ? 4 : 1);
    check("full_tmo", timeout_err, 0);

    // Mid-sequence request pulse: outputs drop without a clock, then restart.
    req_pulse();
    edges_until(1, 200, e);
    repeat (2) @(posedge clk);
    #3 rst_req_n = 1'b0;
    #1;
    check("mid_stage_async", stage_rst_n, 0);
    check("mid_busy_async", seq_busy, 0);
    #14 rst_req_n = 1'b1;
    edges_until(0, 200, e);
    check("mid_restart_rel0", e, SYNC + 1 + SDLY);

    // Stage 2 never acknowledged.
    never_idx = 2;
    req_pulse();
    edges_until(2, 300, e);
    edges_until(3, 300, e);
    check("tmo_gap3", e, ACK_MODE ? ATO + SDLY : SDLY);
    check("tmo_flag", timeout_err, ACK_MODE);
    @(posedge clk);
    #3 rst_req_n = 1'b0;
    #1;
    check("tmo_hold_pulse", timeout_err, ACK_MODE);
    check("tmo_pulse_stage", stage_rst_n, 0);
    rst_req_n = 1'b1;
    never_idx = NUM;

    // Acks pre-asserted on every bit.
    pol = P_ALL;
    req_pulse();
    edges_until(0, 200, e);
    check("all_rel0", e, SYNC + 1 + SDLY);
    for (int i = 1; i < NUM; i++) begin
      edges_until(i, 200, e);
      check("all_gap", e, ACK_MODE ? SDLY + 1 : SDLY);
    end

    // Randomized acks and reset pulses against the model.
    for (int it = 0; it < 30; it++) begin
      pol = $urandom_range(1, 3);
      never_idx = $urandom_range(0, NUM + 1);
      for (int i = 0; i < NUM; i++) ack_dly[i] = $urandom_range(1, 6);
      kind = $urandom_range(0, 4);
      @(posedge clk);
      case (kind)
        0: begin
          #($urandom_range(1, 2)) rst_req_n = 1'b0;
          #($urandom_range(1, 2)) rst_req_n = 1'b1;
        end
        1: begin
          #3 rst_req_n = 1'b0;
          repeat ($urandom_range(1, 4)) @(posedge clk);
          #3 rst_req_n = 1'b1;
        end
        2: begin
          #1 rst_n = 1'b0;
          #2 rst_n = 1'b1;
        end
        default: ;
      endcase
      repeat ($urandom_range(10, 150)) @(posedge clk);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
